// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue decision and long-latency register scoreboard.
// Define DUAL_ISSUE_EN to enable slot-1 issue; otherwise issue is single.
package issue_pkg;
    typedef struct packed {
        logic [15:0]     tag;
        logic [4:0]      w_reg;
        logic [1:0][4:0] r_reg;
    } inst_t;
endpackage

module issue_ctrl
    import issue_pkg::*;
#(
    parameter int LOAD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  inst_t     [1:0] inst_i,
    input  logic      [1:0] inst_valid_i,
    input  logic      [1:0] long_lat_i,
    input  logic      [1:0] serial_i,
    input  logic            exe_stall_i,
    input  logic            flush_i,
    output logic      [1:0] issue_num_o,
    output logic            backend_stall_o,
    output inst_t     [1:0] issue_o,
    output logic      [1:0] issue_valid_o
);

    localparam int CW = $clog2(LOAD_LAT + 1);

    logic [CW-1:0] cnt [32];
    logic [31:0]   busy;
    logic          drained;
    logic          ok0;
    logic          ok1;
    logic          set0;
    logic          set1;

    // Register busy map; r0 is never tracked.
    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = (cnt[r] != '0);
        end
        drained = (busy == '0);
    end

    // Slot-0 issue: operands/dest free, serial ops wait for full drain.
    always_comb begin
        ok0 = inst_valid_i[0] && !exe_stall_i && !flush_i
           && !busy[inst_i[0].r_reg[0]]
           && !busy[inst_i[0].r_reg[1]]
           && !busy[inst_i[0].w_reg]
           && (!serial_i[0] || drained);
    end

`ifdef DUAL_ISSUE_EN
    logic raw01;
    logic waw01;

    // Slot-1 issue: pair hazards and shared memory/MDU port.
    always_comb begin
        raw01 = (inst_i[0].w_reg != '0)
             && ((inst_i[1].r_reg[0] == inst_i[0].w_reg)
              || (inst_i[1].r_reg[1] == inst_i[0].w_reg));
        waw01 = long_lat_i[0] && (inst_i[0].w_reg != '0)
             && (inst_i[0].w_reg == inst_i[1].w_reg);
        ok1 = ok0 && inst_valid_i[1]
           && !serial_i[0] && !serial_i[1]
           && !(long_lat_i[0] && long_lat_i[1])
           && !busy[inst_i[1].r_reg[0]]
           && !busy[inst_i[1].r_reg[1]]
           && !busy[inst_i[1].w_reg]
           && !raw01 && !waw01;
    end
`else
    logic unused_slot1;

    // Single-issue build: slot 1 never issues.
    always_comb begin
        ok1 = 1'b0;
        unused_slot1 = ^{inst_valid_i[1], long_lat_i[1], serial_i[1]};
    end
`endif

    // Issue count to the FIFO and scoreboard set strobes.
    always_comb begin
        issue_num_o     = {1'b0, ok0} + {1'b0, ok1};
        backend_stall_o = exe_stall_i;
        set0 = ok0 && long_lat_i[0] && (inst_i[0].w_reg != '0);
        set1 = ok1 && long_lat_i[1] && (inst_i[1].w_reg != '0);
    end

    // Countdown per register; a new long-latency write reloads it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else if (!exe_stall_i) begin
            for (int r = 0; r < 32; r++) begin
                if ((set0 && inst_i[0].w_reg == 5'(r))
                 || (set1 && inst_i[1].w_reg == 5'(r))) begin
                    cnt[r] <= CW'(LOAD_LAT);
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
        end
    end

    // Issue valid: flush kills, stall holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_valid_o <= 2'b00;
        end else if (flush_i) begin
            issue_valid_o <= 2'b00;
        end else if (!exe_stall_i) begin
            issue_valid_o <= {ok1, ok0};
        end
    end

    // Issue payload; contents only meaningful under issue_valid_o.
    always_ff @(posedge clk) begin
        if (!flush_i && !exe_stall_i) begin
            issue_o <= inst_i;
        end
    end

endmodule
